// File: rtl/data_mem_mmio_if.sv
// CPU load/store port of the data-memory / IO map.
// master = CPU side, slave = data_mem_mmio side.
interface data_mem_mmio_if #(
  parameter int DATA_W = 16
);
  logic              clk_en;
  logic              write_pi;
  logic [DATA_W-1:0] wdata_pi;
  logic [DATA_W-1:0] rdata_po;
  logic [15:0]       addr_pi;

  modport master (output clk_en, write_pi, wdata_pi, addr_pi, input rdata_po);
  modport slave  (input clk_en, write_pi, wdata_pi, addr_pi, output rdata_po);
endinterface

// File: rtl/data_mem_mmio.sv
// Data memory and IO map: word RAM, switches/LEDs, display channels with
// blink mask, sticky button capture (write-1-to-clear), RTC and an irq line.
// Define DATA_MEM_TIMER_EN to build the countdown timer at 0xB000/0xB001;
// without it those addresses are unmapped and the done flag is tied low.
// Reads are combinational; writes land on clk_pi when write_pi && clk_en.
module data_mem_mmio #(
  parameter int DATA_W    = 16,
  parameter int RAM_DEPTH = 256,
  parameter int NUM_LED   = 8,
  parameter int NUM_SW    = 8,
  parameter int NUM_BTN   = 5,
  parameter int NUM_DISP  = 2
) (
  input  logic                       clk_pi,
  input  logic                       reset_pi,
  data_mem_mmio_if.slave             bus,
  input  logic [NUM_BTN-1:0]         bt_pi,
  input  logic [NUM_SW-1:0]          sw_pi,
  input  logic [15:0]                rtc_pi,
  output logic [NUM_LED-1:0]         led_po,
  output logic [NUM_DISP*DATA_W-1:0] disp_num_po,
  output logic [NUM_DISP-1:0]        blink_en_po,
  output logic                       irq_po
);

  localparam int          RAM_AW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [16:0] RAM_END  = 17'(RAM_DEPTH);
  localparam logic [15:0] A_IO     = 16'h8000;
  localparam logic [15:0] A_DISP   = 16'h9000;
  localparam logic [15:0] DISP_END = 16'(32'h9000 + NUM_DISP);
  localparam logic [15:0] A_BLINK  = 16'h9100;
  localparam logic [15:0] A_BTN    = 16'hA000;
  localparam logic [15:0] A_TCNT   = 16'hB000;
  localparam logic [15:0] A_TDONE  = 16'hB001;
  localparam logic [15:0] A_RTC    = 16'hF000;

  logic              we;
  logic              ram_hit;
  logic              disp_hit;
  logic [DATA_W-1:0] ram  [RAM_DEPTH];
  logic [DATA_W-1:0] disp [NUM_DISP];
  logic [DATA_W-1:0] rdata;

  logic [NUM_BTN-1:0] bt_s1, bt_s2, bt_s3;
  logic [NUM_BTN-1:0] bt_rise, bt_clr;
  logic [NUM_BTN-1:0] cap_q, cap_next;
  logic               done_q, done_next;

  assign we       = bus.write_pi && bus.clk_en;
  assign ram_hit  = {1'b0, bus.addr_pi} < RAM_END;
  assign disp_hit = (bus.addr_pi >= A_DISP) && (bus.addr_pi < DISP_END);

  // Rise seen on the synchronised level; a clear never beats a fresh rise.
  assign bt_rise  = bt_s2 & ~bt_s3;
  assign bt_clr   = (we && bus.addr_pi == A_BTN) ? bus.wdata_pi[NUM_BTN-1:0] : '0;
  assign cap_next = (cap_q & ~bt_clr) | bt_rise;

`ifdef DATA_MEM_TIMER_EN
  logic [DATA_W-1:0] tcnt_q, tcnt_next;
  logic              t_load, t_dec, t_clr;

  assign t_load = we && bus.addr_pi == A_TCNT;
  assign t_dec  = bus.clk_en && (tcnt_q != '0);
  assign t_clr  = we && bus.addr_pi == A_TDONE && bus.wdata_pi[0];

  // Next timer state: load beats decrement; the 1->0 step beats a clear.
  always_comb begin
    tcnt_next = tcnt_q;
    if (t_load)
      tcnt_next = bus.wdata_pi;
    else if (t_dec)
      tcnt_next = tcnt_q - 1'b1;
    done_next = (done_q & ~t_clr) | (!t_load && t_dec && tcnt_q == DATA_W'(1));
  end

  // Timer count and sticky done flag.
  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      tcnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_next;
      done_q <= done_next;
    end
  end
`else
  assign done_q    = 1'b0;
  assign done_next = 1'b0;
`endif

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk_pi) begin
    if (we && ram_hit)
      ram[bus.addr_pi[RAM_AW-1:0]] <= bus.wdata_pi;
  end

  // Peripheral registers, button synchroniser/capture and registered irq.
  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      led_po      <= '0;
      blink_en_po <= '0;
      for (int unsigned i = 0; i < NUM_DISP; i++)
        disp[i] <= '0;
      bt_s1  <= '0;
      bt_s2  <= '0;
      bt_s3  <= '0;
      cap_q  <= '0;
      irq_po <= 1'b0;
    end else begin
      bt_s1  <= bt_pi;
      bt_s2  <= bt_s1;
      bt_s3  <= bt_s2;
      cap_q  <= cap_next;
      // Built from next-state so irq tracks the visible pending bits exactly.
      irq_po <= (|cap_next) | done_next;
      if (we) begin
        if (bus.addr_pi == A_IO)
          led_po <= bus.wdata_pi[NUM_LED-1:0];
        if (bus.addr_pi == A_BLINK)
          blink_en_po <= bus.wdata_pi[NUM_DISP-1:0];
        for (int unsigned i = 0; i < NUM_DISP; i++)
          if (disp_hit && bus.addr_pi[3:0] == 4'(i))
            disp[i] <= bus.wdata_pi;
      end
    end
  end

  // Flatten display channels onto the output bus.
  always_comb begin
    disp_num_po = '0;
    for (int unsigned i = 0; i < NUM_DISP; i++)
      disp_num_po[i*DATA_W +: DATA_W] = disp[i];
  end

  // Combinational read mux; anything unmapped reads zero.
  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram[bus.addr_pi[RAM_AW-1:0]];
    end else if (disp_hit) begin
      for (int unsigned i = 0; i < NUM_DISP; i++)
        if (bus.addr_pi[3:0] == 4'(i))
          rdata = disp[i];
    end else begin
      case (bus.addr_pi)
        A_IO:    rdata[NUM_SW-1:0]   = sw_pi;
        A_BLINK: rdata[NUM_DISP-1:0] = blink_en_po;
        A_BTN:   rdata[NUM_BTN-1:0]  = cap_q;
        A_RTC:   rdata[15:0]         = rtc_pi;
`ifdef DATA_MEM_TIMER_EN
        A_TCNT:  rdata               = tcnt_q;
        A_TDONE: rdata[0]            = done_q;
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign bus.rdata_po = rdata;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed vector table, hand-written
// button/reset/timer sequences, then randomized traffic against a map model.
module tb_data_mem_mmio;
  localparam int DW = 16;
  localparam int ND = 2;
  localparam int NB = 5;
  localparam int NL = 8;
  localparam int NS = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     bt;
  logic [NS-1:0]     sw;
  logic [15:0]       rtc;
  logic [NL-1:0]     led;
  logic [ND*DW-1:0]  disp;
  logic [ND-1:0]     blink;
  logic              irq;

  data_mem_mmio_if #(.DATA_W(DW)) bus ();

  data_mem_mmio #(
    .DATA_W(DW), .RAM_DEPTH(256), .NUM_LED(NL), .NUM_SW(NS),
    .NUM_BTN(NB), .NUM_DISP(ND)
  ) dut (
    .clk_pi(clk), .reset_pi(rst), .bus(bus), .bt_pi(bt), .sw_pi(sw),
    .rtc_pi(rtc), .led_po(led), .disp_num_po(disp), .blink_en_po(blink),
    .irq_po(irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- reference model of the memory map ----------------
  logic [15:0] m_ram [256];
  bit          m_ram_ok [256];
  logic [7:0]  m_led;
  logic [15:0] m_disp [ND];
  logic [1:0]  m_blink;
  logic [4:0]  m_cap;
  logic [15:0] m_cnt;
  bit          m_done;
  // Last three edge samples of the buttons, oldest first: a press becomes
  // a capture event two samples after it is first seen.
  logic [4:0]  bt_q [$];

  function automatic bit m_irq();
    return (m_cap != 0) || m_done;
  endfunction

  task automatic model_reset();
    m_led = 0; m_blink = 0; m_cap = 0; m_cnt = 0; m_done = 0;
    for (int i = 0; i < ND; i++) m_disp[i] = 0;
    bt_q = '{5'd0, 5'd0, 5'd0};
  endtask

  task automatic model_edge();
    bit          wr, set_done;
    logic [15:0] a, d;
    logic [4:0]  rise, clr;
    wr = bus.write_pi && bus.clk_en;
    a  = bus.addr_pi;
    d  = bus.wdata_pi;
    rise = bt_q[1] & ~bt_q[0];
    bt_q.push_back(bt);
    void'(bt_q.pop_front());
    clr = (wr && a == 16'hA000) ? d[4:0] : 5'd0;
    m_cap = (m_cap & ~clr) | rise;
    if (wr && a < 16'd256) begin
      m_ram[a[7:0]] = d;
      m_ram_ok[a[7:0]] = 1'b1;
    end
    if (wr && a == 16'h8000) m_led = d[7:0];
    if (wr && a == 16'h9000) m_disp[0] = d;
    if (wr && a == 16'h9001) m_disp[1] = d;
    if (wr && a == 16'h9100) m_blink = d[1:0];
    set_done = 1'b0;
`ifdef DATA_MEM_TIMER_EN
    if (wr && a == 16'hB000) m_cnt = d;
    else if (bus.clk_en && m_cnt != 0) begin
      m_cnt = m_cnt - 16'd1;
      if (m_cnt == 0) set_done = 1'b1;
    end
    if (wr && a == 16'hB001 && d[0]) m_done = 1'b0;
    if (set_done) m_done = 1'b1;
`endif
  endtask

  function automatic logic [15:0] mread(input logic [15:0] a);
    if (a < 16'd256) return m_ram[a[7:0]];
    case (a)
      16'h8000: return {8'h00, sw};
      16'h9000: return m_disp[0];
      16'h9001: return m_disp[1];
      16'h9100: return {14'h0, m_blink};
      16'hA000: return {11'h0, m_cap};
      16'hF000: return rtc;
`ifdef DATA_MEM_TIMER_EN
      16'hB000: return m_cnt;
      16'hB001: return {15'h0, m_done};
`endif
      default:  return 16'h0000;
    endcase
  endfunction

  // One clock edge: DUT and model consume the same stable inputs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit en, input bit wr, input logic [15:0] a, input logic [15:0] d);
    bus.clk_en = en; bus.write_pi = wr; bus.addr_pi = a; bus.wdata_pi = d;
  endtask

  task automatic rd(input string nm, input logic [15:0] a, input logic [15:0] exp);
    bus.write_pi = 1'b0; bus.addr_pi = a;
    #1;
    chk(nm, bus.rdata_po, exp);
  endtask

  typedef struct {
    bit          en;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] raddr;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] addrs [15];
    logic [15:0] a;

    rst = 1'b1; bt = '0; sw = 8'hA5; rtc = 16'h0042;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    model_reset();
    for (int i = 0; i < 256; i++) m_ram_ok[i] = 1'b0;
    #12 rst = 1'b0;
    #1;
    chk("rst_led", led, 0);
    chk("rst_disp", disp, 0);
    chk("rst_blink", blink, 0);
    chk("rst_irq", irq, 0);
    rd("rst_cap", 16'hA000, 16'h0000);

    // ---------------- directed vector table ----------------
    vt.push_back('{1'b1, 1'b1, 16'h0005, 16'h1234, 16'h0005, 16'h1234});
    vt.push_back('{1'b1, 1'b1, 16'h00FF, 16'hBEEF, 16'h00FF, 16'hBEEF});
    vt.push_back('{1'b0, 1'b1, 16'h0005, 16'h5555, 16'h0005, 16'h1234});
    vt.push_back('{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h8000, 16'h00A5});
    vt.push_back('{1'b1, 1'b1, 16'h8000, 16'hFF3C, 16'h8000, 16'h00A5});
    vt.push_back('{1'b1, 1'b1, 16'h9001, 16'h4321, 16'h9001, 16'h4321});
    vt.push_back('{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h9000, 16'h0000});
    vt.push_back('{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h9002, 16'h0000});
    vt.push_back('{1'b1, 1'b1, 16'h9100, 16'hFFFF, 16'h9100, 16'h0003});
    vt.push_back('{1'b1, 1'b1, 16'hF000, 16'h1111, 16'hF000, 16'h0042});
    vt.push_back('{1'b1, 1'b1, 16'h7000, 16'hAAAA, 16'h7000, 16'h0000});
    vt.push_back('{1'b1, 1'b1, 16'h9002, 16'h7777, 16'h9002, 16'h0000});
    vt.push_back('{1'b1, 1'b1, 16'hA000, 16'h001F, 16'hA000, 16'h0000});
    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].wr, vt[i].addr, vt[i].wdata);
      step();
      bus.clk_en = 1'b1;
      rd($sformatf("vec%0d", i), vt[i].raddr, vt[i].exp);
    end
    chk("led_3c", led, 32'h3C);
    chk("disp_ch1_ch0", disp, 32'h4321_0000);
    chk("blink_11", blink, 2'b11);

    // ---------------- button capture ----------------
    drive(1'b1, 1'b0, 16'hA000, 16'h0000);
    bt = 5'b00100;
    step(); rd("btn_lat1", 16'hA000, 16'h0000);
    step(); rd("btn_lat2", 16'hA000, 16'h0000);
    step(); rd("btn_lat3", 16'hA000, 16'h0004);
    chk("btn_irq", irq, 1);
    step(); bt = '0;
    drive(1'b1, 1'b1, 16'hA000, 16'h0004);
    step();
    rd("btn_clr", 16'hA000, 16'h0000);
    chk("btn_clr_irq", irq, 0);
    for (int i = 0; i < 4; i++) step();
    rd("held_no_reset", 16'hA000, 16'h0000);
    bt = 5'b00100;
    for (int i = 0; i < 3; i++) step();
    bt = '0;
    for (int i = 0; i < 4; i++) step();
    rd("btn_again", 16'hA000, 16'h0004);
    bt = 5'b00100;
    step(); step();
    drive(1'b1, 1'b1, 16'hA000, 16'h0004);
    step();
    rd("set_wins", 16'hA000, 16'h0004);
    chk("set_wins_irq", irq, 1);
    bt = '0;
    drive(1'b1, 1'b1, 16'hA000, 16'h0004);
    step();
    rd("btn_clr2", 16'hA000, 16'h0000);

    // ---------------- reset between clock edges ----------------
    bt = 5'b00001;
    for (int i = 0; i < 3; i++) step();
    bt = '0;
    rd("pre_rst_cap", 16'hA000, 16'h0001);
    chk("pre_rst_led", led, 32'h3C);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_led", led, 0);
    chk("mid_rst_blink", blink, 0);
    chk("mid_rst_disp", disp, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_cap", bus.rdata_po, 0);
    model_reset();
    #2 rst = 1'b0;
    rd("ram_survives_rst", 16'h0005, 16'h1234);
    step();

    // ---------------- timer ----------------
`ifdef DATA_MEM_TIMER_EN
    drive(1'b1, 1'b1, 16'hB000, 16'h0003);
    step();
    rd("tmr_load", 16'hB000, 16'h0003);
    step(); rd("tmr_2", 16'hB000, 16'h0002);
    step(); rd("tmr_1", 16'hB000, 16'h0001);
    rd("tmr_not_done", 16'hB001, 16'h0000);
    step(); rd("tmr_0", 16'hB000, 16'h0000);
    rd("tmr_done", 16'hB001, 16'h0001);
    chk("tmr_irq", irq, 1);
    drive(1'b1, 1'b1, 16'hB001, 16'h0001);
    step();
    rd("tmr_clr", 16'hB001, 16'h0000);
    chk("tmr_clr_irq", irq, 0);
    drive(1'b1, 1'b1, 16'hB000, 16'h0000);
    step(); bus.write_pi = 1'b0; step();
    rd("tmr_load0", 16'hB001, 16'h0000);
    chk("tmr_load0_irq", irq, 0);
`else
    drive(1'b1, 1'b1, 16'hB000, 16'h0003);
    step();
    rd("notmr_cnt", 16'hB000, 16'h0000);
    for (int i = 0; i < 4; i++) step();
    rd("notmr_done", 16'hB001, 16'h0000);
    chk("notmr_irq", irq, 0);
`endif

    // ---------------- randomized traffic vs model ----------------
    addrs = '{16'h0005, 16'h00FF, 16'h0003, 16'h8000, 16'h9000, 16'h9001,
              16'h9002, 16'h9100, 16'hA000, 16'hB000, 16'hB001, 16'hF000,
              16'h7FFF, 16'h0100, 16'hC000};
    for (int c = 0; c < 1000; c++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15))
                                      : addrs[$urandom_range(0, 14)];
      bus.clk_en   = ($urandom_range(0, 3) != 0);
      bus.write_pi = $urandom_range(0, 1) == 1;
      bus.addr_pi  = a;
      bus.wdata_pi = (a == 16'hB000) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 7) == 0) bt[b] = ~bt[b];
      sw  = 8'($urandom);
      rtc = 16'($urandom);
      #1;
      if (!(a < 16'd256 && !m_ram_ok[a[7:0]]))
        chk($sformatf("rand_rd_%0h", a), bus.rdata_po, mread(a));
      chk("rand_led", led, m_led);
      chk("rand_disp", disp, {m_disp[1], m_disp[0]});
      chk("rand_blink", blink, m_blink);
      chk("rand_irq", irq, m_irq());
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
